// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline latches and PC.
// Also tracks halt, the data-memory watchdog and perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DWAIT_MAX = 1024
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_mem,
  input  logic             memread_ex,
  input  logic [4:0]       rw_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             pc_src_mem,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = $clog2(DWAIT_MAX + 1);
  localparam logic [DW-1:0] DMAX = DW'(DWAIT_MAX);

  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;

  state_t          state;
  logic [DW-1:0]   dwait_cnt;
  logic [DW-1:0]   dwait_inc;
  logic            freeze;
  logic            load_use;
  logic            redirect;

  assign freeze   = dmem_req_mem & ~dhit;
  assign load_use = memread_ex & (rw_ex != 5'd0) &
                    ((rw_ex == rs_id) |
                     (uses_rt_id & (rw_ex == rt_id)));
  assign redirect = (state != HALT) & ~freeze & pc_src_mem;
  assign dwait_inc = (dwait_cnt >= DMAX) ? dwait_cnt
                                         : dwait_cnt + DW'(1);

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    halt        = 1'b0;
    if (!nRST) begin
      halt = 1'b0;
    end else if (state == HALT) begin
      halt = 1'b1;
    end else if (freeze) begin
      halt = 1'b0;
    end else if (pc_src_mem) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      dwait_cnt   <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (state != HALT) begin
        if (!pc_en && stall_count != '1)
          stall_count <= stall_count + CNT_W'(1);
        if (redirect && flush_count != '1)
          flush_count <= flush_count + CNT_W'(1);
      end
      unique case (state)
        RUN: begin
          if (freeze) begin
            state     <= DWAIT;
            dwait_cnt <= DW'(1);
            if (DMAX <= DW'(1))
              mem_timeout <= 1'b1;
          end else if (halt_wb) begin
            state <= HALT;
          end
        end
        DWAIT: begin
          if (freeze) begin
            dwait_cnt <= dwait_inc;
            if (dwait_inc >= DMAX)
              mem_timeout <= 1'b1;
          end else begin
            dwait_cnt <= '0;
            state     <= halt_wb ? HALT : RUN;
          end
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table
// plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, dmem_req_mem, memread_ex;
  logic [4:0]  rw_ex, rs_id, rt_id;
  logic        uses_rt_id, pc_src_mem, halt_wb;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        halt, mem_timeout;
  logic [15:0] stall_count, flush_count;

  pipeline_hazard_ctrl #(.CNT_W(16), .DWAIT_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .dhit(dhit),
    .dmem_req_mem(dmem_req_mem),
    .memread_ex(memread_ex),
    .rw_ex(rw_ex), .rs_id(rs_id), .rt_id(rt_id),
    .uses_rt_id(uses_rt_id),
    .pc_src_mem(pc_src_mem), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush),
    .halt(halt), .mem_timeout(mem_timeout),
    .stall_count(stall_count),
    .flush_count(flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {pc,ifid,idex,exmem,memwb,ifid_fl,idex_fl,exmem_fl,halt}
  logic [8:0] ctrl;
  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, halt};

  localparam logic [8:0] RUNV = 9'b11111_000_0;
  localparam logic [8:0] LDU  = 9'b00111_010_0;
  localparam logic [8:0] FWT  = 9'b01111_100_0;
  localparam logic [8:0] RDR  = 9'b11111_111_0;
  localparam logic [8:0] FRZ  = 9'b00000_000_0;
  localparam logic [8:0] HLT  = 9'b00000_000_1;

  typedef struct {
    string      nm;
    logic [3:0] f;
    logic [4:0] rw, rs, rt;
    logic       urt, pcs;
    logic [8:0] e;
    int         sc, fc;
  } vec_t;

  typedef struct {
    string      nm;
    logic [8:0] e;
  } exp_t;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  vec_t vt[14];

  function automatic vec_t mk(string nm, logic [3:0] f,
                              int rw, int rs, int rt,
                              logic urt, logic pcs,
                              logic [8:0] e, int sc, int fc);
    vec_t v;
    v.nm = nm; v.f = f;
    v.rw = 5'(rw); v.rs = 5'(rs); v.rt = 5'(rt);
    v.urt = urt; v.pcs = pcs; v.e = e;
    v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // f = {ihit, dhit, dmem_req_mem, memread_ex}
  task automatic set_in(logic [3:0] f, logic [4:0] rw,
                        logic [4:0] rs, logic [4:0] rt,
                        logic urt, logic pcs, logic hwb);
    {ihit, dhit, dmem_req_mem, memread_ex} = f;
    rw_ex = rw; rs_id = rs; rt_id = rt;
    uses_rt_id = urt; pc_src_mem = pcs; halt_wb = hwb;
  endtask

  task automatic pop_chk();
    exp_t x;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      x = sb.pop_front();
      chk(x.nm, ctrl, x.e);
    end
  endtask

  // Inputs already driven at posedge+1; ends at next posedge+1.
  task automatic cyc(string nm, logic [8:0] e);
    exp_t x;
    x.nm = nm; x.e = e;
    sb.push_back(x);
    @(negedge CLK);
    pop_chk();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    exp_t x;
    nRST = 1'b0;
    set_in(4'b1000, 0, 0, 0, 0, 0, 0);
    #2;
    x.nm = "rst_outs"; x.e = 9'b0;
    sb.push_back(x);
    pop_chk();
    chk("rst_stall", stall_count, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_tmo", mem_timeout, 0);
    @(posedge CLK);
    #1;
    x.nm = "rst_outs_edge"; x.e = 9'b0;
    sb.push_back(x);
    pop_chk();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench time limit");
  end

  int sc0, fc0;

  initial begin
    nRST = 1'b0;
    set_in(4'b1000, 0, 0, 0, 0, 0, 0);

    vt[0]  = mk("normal",      4'b1000, 0, 0, 0, 0, 0, RUNV, 0, 0);
    vt[1]  = mk("ldu_rs",      4'b1001, 8, 8, 0, 0, 0, LDU,  1, 0);
    vt[2]  = mk("ldu_r0",      4'b1001, 0, 0, 0, 1, 0, RUNV, 1, 0);
    vt[3]  = mk("ldu_rt",      4'b1001, 5, 1, 5, 1, 0, LDU,  2, 0);
    vt[4]  = mk("rt_unused",   4'b1001, 5, 1, 5, 0, 0, RUNV, 2, 0);
    vt[5]  = mk("no_load",     4'b1000, 8, 8, 8, 1, 0, RUNV, 2, 0);
    vt[6]  = mk("fetch_wait",  4'b0000, 0, 0, 0, 0, 0, FWT,  3, 0);
    vt[7]  = mk("ldu_noihit",  4'b0001, 7, 7, 0, 0, 0, LDU,  4, 0);
    vt[8]  = mk("redir_noih",  4'b0000, 0, 0, 0, 0, 1, RDR,  4, 1);
    vt[9]  = mk("redir_ldu",   4'b1001, 9, 9, 0, 0, 1, RDR,  4, 2);
    vt[10] = mk("frz_redir",   4'b1010, 0, 0, 0, 0, 1, FRZ,  5, 2);
    vt[11] = mk("frz_hold",    4'b1010, 0, 0, 0, 0, 1, FRZ,  6, 2);
    vt[12] = mk("dhit_redir",  4'b1110, 0, 0, 0, 0, 1, RDR,  6, 3);
    vt[13] = mk("dhit_normal", 4'b1110, 0, 0, 0, 0, 0, RUNV, 6, 3);

    @(posedge CLK);
    #1;
    do_reset();

    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].f, vt[i].rw, vt[i].rs, vt[i].rt,
             vt[i].urt, vt[i].pcs, 1'b0);
      cyc(vt[i].nm, vt[i].e);
      chk({vt[i].nm, "_sc"}, stall_count, vt[i].sc);
      chk({vt[i].nm, "_fc"}, flush_count, vt[i].fc);
    end
    chk("tbl_tmo", mem_timeout, 0);

    // Three-cycle freeze, then data hit.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1010, 0, 0, 0, 0, 0, 0);
      cyc("dw3_frz", FRZ);
    end
    set_in(4'b1110, 0, 0, 0, 0, 0, 0);
    cyc("dw3_hit", RUNV);
    chk("dw3_sc", stall_count, 3);
    chk("dw3_tmo", mem_timeout, 0);
    set_in(4'b1000, 0, 0, 0, 0, 0, 0);
    cyc("dw3_after", RUNV);

    // Watchdog at DWAIT_MAX=4.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(4'b1010, 0, 0, 0, 0, 0, 0);
      cyc("tmo_frz", FRZ);
    end
    chk("tmo_pre", mem_timeout, 0);
    set_in(4'b1010, 0, 0, 0, 0, 0, 0);
    cyc("tmo_frz4", FRZ);
    chk("tmo_set", mem_timeout, 1);
    chk("tmo_sc", stall_count, 4);
    set_in(4'b1110, 0, 0, 0, 0, 0, 0);
    cyc("tmo_hit", RUNV);
    chk("tmo_sticky", mem_timeout, 1);

    // Reset in the middle of a long data wait.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(4'b1010, 0, 0, 0, 0, 0, 0);
      cyc("mid_frz", FRZ);
    end
    chk("mid_sc5", stall_count, 5);
    do_reset();
    set_in(4'b1000, 0, 0, 0, 0, 0, 0);
    cyc("mid_run", RUNV);
    chk("mid_sc0", stall_count, 0);

    // Halt: blocked by freeze, then taken, then held.
    do_reset();
    set_in(4'b1010, 0, 0, 0, 0, 0, 1);
    cyc("hlt_frz", FRZ);
    set_in(4'b1000, 0, 0, 0, 0, 0, 0);
    cyc("hlt_notyet", RUNV);
    set_in(4'b1000, 0, 0, 0, 0, 0, 1);
    cyc("hlt_wb", RUNV);
    sc0 = stall_count;
    fc0 = flush_count;
    chk("hlt_sc_pre", sc0, 1);
    for (int i = 0; i < 10; i++) begin
      set_in(4'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
      cyc("hlt_hold", HLT);
    end
    chk("hlt_sc", stall_count, sc0);
    chk("hlt_fc", flush_count, fc0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
